sig_pack: RTL

SIG_PACK -- requirements
Module: sig_pack

---
 rtl/sig_pack.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sig_pack.sv
// -----------------------------------------------------------------------------
// sig_pack
// Packs one radar frame per PRI trigger into a stream of 64-bit words:
// a header word, SAMP_NUM sample words and a tail word. The words go through
// a first-word-fall-through FIFO to a valid/ready output.
//
// Parameters
//   SAMP_NUM     sample words per frame (1..65535)
//   FIFO_AW      FIFO address width, depth = 2**FIFO_AW words
//
// Ports
//   clk_100M     system clock, every register uses its rising edge
//   rst          synchronous active-high reset
//   PRI          pulse repetition trigger, a frame starts on its rising edge
//   work_mode, wave_code, hor_code, pri_code
//                mode codes, latched when the frame starts
//   AD_he, AD_fw, AD_fy
//                sum / azimuth / elevation samples, valid every cycle
//   dout         packed stream word
//   dout_valid   dout holds a word
//   dout_ready   downstream accepts the word
//   dout_sof     dout is a header word
//   dout_eof     dout is a tail word
//   busy         the FSM is not in IDLE
//   ovf_err      sticky: a FIFO write was dropped
//   pri_miss     sticky: a PRI edge arrived while busy
//   o_dbg_state  current FSM state (IDLE=0, HEAD=1, DATA=2, TAIL=3)
//
// Output handshake: a word transfers on every rising clk_100M edge where
// dout_valid=1 and dout_ready=1. While dout_valid=1 and dout_ready=0 the word
// and its sof/eof flags stay unchanged. dout_valid never waits on dout_ready.
// -----------------------------------------------------------------------------
module sig_pack #(
  parameter int SAMP_NUM = 256,
  parameter int FIFO_AW  = 6
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic        PRI,
  input  logic [7:0]  work_mode,
  input  logic [7:0]  wave_code,
  input  logic [7:0]  hor_code,
  input  logic [15:0] pri_code,
  input  logic [15:0] AD_he,
  input  logic [15:0] AD_fw,
  input  logic [15:0] AD_fy,
  output logic [63:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_sof,
  output logic        dout_eof,
  output logic        busy,
  output logic        ovf_err,
  output logic        pri_miss,
  output logic [1:0]  o_dbg_state
);

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0] LAST_IDX = 16'(SAMP_NUM - 1);
  localparam logic [15:0] SAMP_W   = 16'(SAMP_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_pri_d;
  logic          w_start;
  logic [15:0]   r_idx;
  logic [7:0]    r_work_mode;
  logic [7:0]    r_wave_code;
  logic [7:0]    r_hor_code;
  logic [15:0]   r_pri_code;
  logic [7:0]    r_frame_cnt;
  logic          r_ovf_frame;
  logic          r_ovf_err;
  logic          r_pri_miss;

  // FIFO entry layout: {sof, eof, word[63:0]}
  logic [65:0]   r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_space;
  logic          w_wr_req;
  logic          w_wr_en;
  logic          w_drop;
  logic [65:0]   w_wr_data;
  logic [65:0]   w_head;

  assign w_start = PRI & ~r_pri_d;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_pop   = ~w_empty & dout_ready;
  // A pop in the same cycle frees the slot the write needs.
  assign w_space = ~w_full | w_pop;
  assign w_wr_en = w_wr_req & w_space;
  assign w_drop  = w_wr_req & ~w_space;

  // Next state and the word written this cycle.
  always_comb begin
    w_next    = r_state;
    w_wr_req  = 1'b0;
    w_wr_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_HEAD;
      end
      S_HEAD: begin
        w_wr_req  = 1'b1;
        w_wr_data = {1'b1, 1'b0, 16'hEB90, r_work_mode, r_wave_code,
                     r_hor_code, r_frame_cnt, r_pri_code};
        w_next    = S_DATA;
      end
      S_DATA: begin
        w_wr_req  = 1'b1;
        w_wr_data = {1'b0, 1'b0, AD_he, AD_fw, AD_fy, r_idx};
        if (r_idx == LAST_IDX) w_next = S_TAIL;
      end
      S_TAIL: begin
        w_wr_data = {1'b0, 1'b1, 16'h09D7, r_frame_cnt, 7'b0, r_ovf_frame,
                     SAMP_W, 16'h0000};
        // The tail is only requested when it fits, so it is never dropped;
        // otherwise the FSM waits here.
        if (w_space) begin
          w_wr_req = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pri_d     <= 1'b0;
      r_idx       <= '0;
      r_work_mode <= '0;
      r_wave_code <= '0;
      r_hor_code  <= '0;
      r_pri_code  <= '0;
      r_frame_cnt <= '0;
      r_ovf_frame <= 1'b0;
      r_ovf_err   <= 1'b0;
      r_pri_miss  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state <= w_next;
      r_pri_d <= PRI;

      if (r_state == S_IDLE && w_start) begin
        r_work_mode <= work_mode;
        r_wave_code <= wave_code;
        r_hor_code  <= hor_code;
        r_pri_code  <= pri_code;
        r_ovf_frame <= 1'b0;
      end

      if (r_state == S_DATA) r_idx <= r_idx + 16'd1;
      else                   r_idx <= '0;

      // The count advances only when the tail is actually written.
      if (r_state == S_TAIL && w_space) r_frame_cnt <= r_frame_cnt + 8'd1;

      if (w_drop) begin
        r_ovf_frame <= 1'b1;
        r_ovf_err   <= 1'b1;
      end

      if (w_start && r_state != S_IDLE) r_pri_miss <= 1'b1;

      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible once the pointers cover it.
  always_ff @(posedge clk_100M) begin
    if (w_wr_en) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_wr_data;
  end

  assign w_head      = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign dout_valid  = ~w_empty;
  assign dout        = w_empty ? 64'h0 : w_head[63:0];
  assign dout_sof    = ~w_empty & w_head[65];
  assign dout_eof    = ~w_empty & w_head[64];
  assign busy        = (r_state != S_IDLE);
  assign ovf_err     = r_ovf_err;
  assign pri_miss    = r_pri_miss;
  assign o_dbg_state = r_state;

endmodule
